// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings for the snake body engine.
//   dir_t    - heading encodings used on the dir port and in the heading register
//   state_t  - step-processing FSM states
//   opposite_dir() - returns the heading pointing the other way
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Opposite headings differ in both bits with this encoding.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return d ^ 2'b11;
  endfunction

endpackage

// File: rtl/snake_seg_store.sv
// snake_seg_store: MAX_LEN-deep register file of (x,y) segment coordinates.
// Ports:
//   clk            - rising-edge clock
//   load           - reload the initial snake (highest priority)
//   shift          - push new_x/new_y into slot 0, every slot moves down one
//   new_x, new_y   - next head coordinate
//   rd_idx         - renderer read index -> rd_x, rd_y (raw, 0 past MAX_LEN)
//   scan_idx       - collision-scan read index -> scan_x, scan_y
//   head_x, head_y - slot 0
module snake_seg_store
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int STEP     = 10,
  parameter int X_INIT   = 40,
  parameter int Y_INIT   = 60,
  parameter int INIT_LEN = 2,
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          load,
  input  logic          shift,
  input  logic [XW-1:0] new_x,
  input  logic [YW-1:0] new_y,
  input  logic [LW-1:0] rd_idx,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  input  logic [LW-1:0] scan_idx,
  output logic [XW-1:0] scan_x,
  output logic [YW-1:0] scan_y,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y
);

  localparam int IW = $clog2(MAX_LEN);

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];

  // Storage: initial-snake load or one-slot shift with the new head in front.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x[i] <= XW'(X_INIT - i * STEP);
          seg_y[i] <= YW'(Y_INIT);
        end else begin
          seg_x[i] <= '0;
          seg_y[i] <= '0;
        end
      end
    end else if (shift) begin
      seg_x[0] <= new_x;
      seg_y[0] <= new_y;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
    end
  end

  // Two combinational read ports; indices beyond the array read as (0,0).
  always_comb begin
    rd_x   = '0;
    rd_y   = '0;
    scan_x = '0;
    scan_y = '0;
    if (rd_idx < LW'(MAX_LEN)) begin
      rd_x = seg_x[rd_idx[IW-1:0]];
      rd_y = seg_y[rd_idx[IW-1:0]];
    end else begin
      rd_x = '0;
      rd_y = '0;
    end
    if (scan_idx < LW'(MAX_LEN)) begin
      scan_x = seg_x[scan_idx[IW-1:0]];
      scan_y = seg_y[scan_idx[IW-1:0]];
    end else begin
      scan_x = '0;
      scan_y = '0;
    end
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: snake body tracker with wall check, growth and a
// multi-cycle self-collision scan.
// Ports:
//   clk, rst, init        - clock, sync active-high reset, sync reload (same effect)
//   step, dir, grow       - move request, requested heading, keep-tail flag
//   busy, done            - step in progress / one-cycle end-of-step pulse
//   hit_wall, hit_self    - sticky collision flags
//   length, head_x/head_y - segment count and segment 0
//   rd_idx -> rd_x, rd_y, rd_valid - combinational segment read for the renderer
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int STEP     = 10,
  parameter int XMAX     = 150,
  parameter int YMAX     = 110,
  parameter int X_INIT   = 40,
  parameter int Y_INIT   = 60,
  parameter int INIT_LEN = 2,
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          step,
  input  logic [1:0]    dir,
  input  logic          grow,
  output logic          busy,
  output logic          done,
  output logic          hit_wall,
  output logic          hit_self,
  output logic [LW-1:0] length,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  input  logic [LW-1:0] rd_idx,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  output logic          rd_valid
);

  state_t        state;
  logic [1:0]    heading;
  logic [LW-1:0] scan_idx;

  logic          reload;
  logic          accept;
  logic          blocked;
  logic          do_shift;
  logic          grow_ok;
  logic [LW-1:0] new_len;
  logic [1:0]    new_heading;
  logic [XW:0]   next_x_ext;
  logic [YW:0]   next_y_ext;
  logic [XW-1:0] raw_x, scan_x;
  logic [YW-1:0] raw_y, scan_y;
  logic          scan_hit;

  assign reload   = rst | init;
  assign accept   = (state == IDLE) && step && !hit_wall && !hit_self;
  assign do_shift = accept && !blocked && !reload;
  assign grow_ok  = grow && (length < LW'(MAX_LEN));
  assign new_len  = grow_ok ? (length + LW'(1)) : length;
  assign scan_hit = (scan_x == head_x) && (scan_y == head_y);

  // Heading filter and next-head / wall computation in one extra bit of range.
  always_comb begin
    new_heading = dir;
    next_x_ext  = {1'b0, head_x};
    next_y_ext  = {1'b0, head_y};
    blocked     = 1'b0;
    if (dir == opposite_dir(heading)) begin
      new_heading = heading;
    end else begin
      new_heading = dir;
    end
    case (new_heading)
      DIR_RIGHT: begin
        next_x_ext = {1'b0, head_x} + (XW+1)'(STEP);
        blocked    = next_x_ext > (XW+1)'(XMAX);
      end
      DIR_DOWN: begin
        next_y_ext = {1'b0, head_y} + (YW+1)'(STEP);
        blocked    = next_y_ext > (YW+1)'(YMAX);
      end
      DIR_UP: begin
        blocked    = {1'b0, head_y} < (YW+1)'(STEP);
        next_y_ext = {1'b0, head_y} - (YW+1)'(STEP);
      end
      DIR_LEFT: begin
        blocked    = {1'b0, head_x} < (XW+1)'(STEP);
        next_x_ext = {1'b0, head_x} - (XW+1)'(STEP);
      end
      default: begin
        blocked = 1'b0;
      end
    endcase
  end

  snake_seg_store #(
    .MAX_LEN (MAX_LEN),
    .XW      (XW),
    .YW      (YW),
    .STEP    (STEP),
    .X_INIT  (X_INIT),
    .Y_INIT  (Y_INIT),
    .INIT_LEN(INIT_LEN),
    .LW      (LW)
  ) u_store (
    .clk     (clk),
    .load    (reload),
    .shift   (do_shift),
    .new_x   (next_x_ext[XW-1:0]),
    .new_y   (next_y_ext[YW-1:0]),
    .rd_idx  (rd_idx),
    .rd_x    (raw_x),
    .rd_y    (raw_y),
    .scan_idx(scan_idx),
    .scan_x  (scan_x),
    .scan_y  (scan_y),
    .head_x  (head_x),
    .head_y  (head_y)
  );

  // Step FSM: accept/wall/move in IDLE, scan body in CHECK, pulse done in DONE.
  always_ff @(posedge clk) begin
    if (reload) begin
      state    <= IDLE;
      heading  <= DIR_RIGHT;
      length   <= LW'(INIT_LEN);
      hit_wall <= 1'b0;
      hit_self <= 1'b0;
      scan_idx <= LW'(1);
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            heading <= new_heading;
            busy    <= 1'b1;
            if (blocked) begin
              hit_wall <= 1'b1;
              state    <= DONE;
              done     <= 1'b1;
            end else begin
              length   <= new_len;
              scan_idx <= LW'(1);
              if (new_len == LW'(1)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= CHECK;
                done  <= 1'b0;
              end
            end
          end else begin
            busy <= 1'b0;
            done <= 1'b0;
          end
        end
        CHECK: begin
          if (scan_hit) begin
            hit_self <= 1'b1;
          end
          if (scan_idx == length - LW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            scan_idx <= scan_idx + LW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Renderer port: mask slots beyond the live body.
  always_comb begin
    rd_valid = rd_idx < length;
    if (rd_valid) begin
      rd_x = raw_x;
      rd_y = raw_y;
    end else begin
      rd_x = '0;
      rd_y = '0;
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed, table-driven bench for snake_body_engine
// with default parameters, plus hand-written multi-cycle sequences.
module tb_snake_body_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0;
  logic       step = 1'b0;
  logic [1:0] dir = 2'b00;
  logic       grow = 1'b0;
  logic       busy, done, hit_wall, hit_self, rd_valid;
  logic [4:0] length;
  logic [7:0] head_x, rd_x;
  logic [6:0] head_y, rd_y;
  logic [4:0] rd_idx = 5'd0;

  int checks = 0;
  int errors = 0;

  snake_body_engine dut (
    .clk(clk), .rst(rst), .init(init), .step(step), .dir(dir), .grow(grow),
    .busy(busy), .done(done), .hit_wall(hit_wall), .hit_self(hit_self),
    .length(length), .head_x(head_x), .head_y(head_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_init;
    logic [1:0] d;
    logic       g;
    int         ex;
    int         ey;
    int         len;
    int         lat;
    int         wall;
    int         hs;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_init();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Issue one step and return edges until done (bounded).
  task automatic do_step(input logic [1:0] d, input logic g, output int lat);
    @(negedge clk);
    step = 1'b1;
    dir  = d;
    grow = g;
    @(negedge clk);
    step = 1'b0;
    grow = 1'b0;
    lat  = 1;
    while (!done && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic read_seg(input int idx, output int x, output int y, output int v);
    rd_idx = 5'(idx);
    #1;
    x = int'(rd_x);
    y = int'(rd_y);
    v = int'(rd_valid);
  endtask

  task automatic run_vectors(input int lo, input int hi);
    int lat;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].do_init) pulse_init();
      do_step(vecs[i].d, vecs[i].g, lat);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d head_x", i), int'(head_x), vecs[i].ex);
      chk($sformatf("v%0d head_y", i), int'(head_y), vecs[i].ey);
      chk($sformatf("v%0d length", i), int'(length), vecs[i].len);
      chk($sformatf("v%0d hit_wall", i), int'(hit_wall), vecs[i].wall);
      chk($sformatf("v%0d hit_self", i), int'(hit_self), vecs[i].hs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, v, cnt, lat;
    int gx [5];
    int gy [5];

    //              init  dir    grow  ex  ey len lat wall self
    vecs[0]  = '{1'b0, 2'b11, 1'b0, 60, 60, 2, 2, 0, 0}; // reversal ignored
    vecs[1]  = '{1'b1, 2'b01, 1'b1, 40, 70, 3, 3, 0, 0};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 40, 80, 4, 4, 0, 0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 40, 90, 5, 5, 0, 0};
    vecs[4]  = '{1'b1, 2'b10, 1'b0, 40, 50, 2, 2, 0, 0};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 40, 40, 2, 2, 0, 0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 40, 30, 2, 2, 0, 0};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 40, 20, 2, 2, 0, 0};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 40, 10, 2, 2, 0, 0};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 40,  0, 2, 2, 0, 0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 40,  0, 2, 1, 1, 0}; // wall
    vecs[11] = '{1'b1, 2'b00, 1'b1, 50, 60, 3, 3, 0, 0};
    vecs[12] = '{1'b0, 2'b00, 1'b1, 60, 60, 4, 4, 0, 0};
    vecs[13] = '{1'b0, 2'b00, 1'b1, 70, 60, 5, 5, 0, 0};
    vecs[14] = '{1'b0, 2'b00, 1'b1, 80, 60, 6, 6, 0, 0};
    vecs[15] = '{1'b0, 2'b01, 1'b0, 80, 70, 6, 6, 0, 0};
    vecs[16] = '{1'b0, 2'b11, 1'b0, 70, 70, 6, 6, 0, 0};
    vecs[17] = '{1'b0, 2'b10, 1'b0, 70, 60, 6, 6, 0, 1}; // self hit

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst length", int'(length), 2);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst hit_wall", int'(hit_wall), 0);
    chk("rst hit_self", int'(hit_self), 0);
    read_seg(0, x, y, v);
    chk("rst seg0 x", x, 40); chk("rst seg0 y", y, 60); chk("rst seg0 valid", v, 1);
    read_seg(1, x, y, v);
    chk("rst seg1 x", x, 30); chk("rst seg1 y", y, 60);
    read_seg(2, x, y, v);
    chk("rst seg2 valid", v, 0); chk("rst seg2 x", x, 0); chk("rst seg2 y", y, 0);

    // Right step with extra step requests during CHECK and DONE (ignored)
    @(negedge clk);
    step = 1'b1; dir = 2'b00; grow = 1'b0;
    @(negedge clk);
    chk("busy after accept", int'(busy), 1);
    chk("no done in CHECK", int'(done), 0);
    dir = 2'b01;
    @(negedge clk);
    chk("done pulse", int'(done), 1);
    @(negedge clk);
    step = 1'b0;
    chk("busy clear", int'(busy), 0);
    chk("done clear", int'(done), 0);
    count_dones(4, cnt);
    chk("busy step ignored dones", cnt, 0);
    chk("right head_x", int'(head_x), 50);
    chk("right head_y", int'(head_y), 60);
    read_seg(1, x, y, v);
    chk("right seg1 x", x, 40); chk("right seg1 y", y, 60);

    // Reversal, then growth downwards
    run_vectors(0, 3);
    gx = '{40, 40, 40, 40, 30};
    gy = '{90, 80, 70, 60, 60};
    for (int i = 0; i < 5; i++) begin
      read_seg(i, x, y, v);
      chk($sformatf("grow seg%0d x", i), x, gx[i]);
      chk($sformatf("grow seg%0d y", i), y, gy[i]);
    end
    read_seg(5, x, y, v);
    chk("grow seg5 valid", v, 0);

    // Up to the wall; further steps are ignored until init
    run_vectors(4, 10);
    @(negedge clk);
    step = 1'b1; dir = 2'b10;
    @(negedge clk);
    step = 1'b0;
    count_dones(5, cnt);
    chk("step after wall dones", cnt, 0);
    chk("step after wall head_y", int'(head_y), 0);
    pulse_init();
    chk("init clears wall", int'(hit_wall), 0);
    chk("init head_x", int'(head_x), 40);
    chk("init head_y", int'(head_y), 60);

    // Self collision
    run_vectors(11, 17);
    read_seg(4, x, y, v);
    chk("self seg4 x", x, 70); chk("self seg4 y", y, 60);
    @(negedge clk);
    step = 1'b1; dir = 2'b00;
    @(negedge clk);
    step = 1'b0;
    count_dones(8, cnt);
    chk("step after self dones", cnt, 0);

    // init in the middle of a CHECK scan
    pulse_init();
    chk("init clears self", int'(hit_self), 0);
    @(negedge clk);
    step = 1'b1; dir = 2'b00; grow = 1'b1;
    @(negedge clk);
    step = 1'b0; grow = 1'b0;
    chk("midscan busy", int'(busy), 1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("midscan busy after init", int'(busy), 0);
    chk("midscan done after init", int'(done), 0);
    chk("midscan length", int'(length), 2);
    chk("midscan head_x", int'(head_x), 40);
    chk("midscan head_y", int'(head_y), 60);
    read_seg(1, x, y, v);
    chk("midscan seg1 x", x, 30); chk("midscan seg1 y", y, 60);
    count_dones(8, cnt);
    chk("midscan no done", cnt, 0);

    // One more move after the abort to show the block is usable again
    do_step(2'b00, 1'b0, lat);
    chk("post-init latency", lat, 2);
    chk("post-init head_x", int'(head_x), 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Parametrised snake body tracker. Holds up to MAX_LEN segment coordinates, advances the head one cell per step request, and supports growth. Runs a multi-cycle self-collision scan after each move and detects walls before each move.
- Sits between the game-control FSM, which issues step/dir/grow, and the renderer, which reads segments through an indexed read port.
- Replaces the fixed two-segment shift register and free-running head counters.

Parameters:
- MAX_LEN, 16, maximum segment count (at least 2).
- XW, 8, x coordinate width.
- YW, 7, y coordinate width.
- STEP, 10, pixels moved per step (cell size).
- XMAX, 150, largest legal head x.
- YMAX, 110, largest legal head y.
- X_INIT, 40, initial head x.
- Y_INIT, 60, initial head y.
- INIT_LEN, 2, length after reset/init (1..MAX_LEN).
- LW, $clog2(MAX_LEN+1), length/index width.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- init  in  1  synchronous reload of the initial snake; same effect as Reset.
- step  in  1  request one move; accepted only when busy=0 and not dead.
- dir  in  2  requested heading: 00 right, 01 down, 10 up, 11 left.
- grow  in  1  sampled with an accepted step; keep the tail.
- busy  out  1  high while a step is being processed.
- done  out  1  one-cycle pulse at the end of every accepted step.
- hit_wall  out  1  sticky: a move was blocked by a wall.
- hit_self  out  1  sticky: the head overlapped a body segment.
- length  out  LW  current segment count.
- head_x  out  XW  segment 0 x.
- head_y  out  YW  segment 0 y.
- rd_idx  in  LW  segment index to read.
- rd_x  out  XW  combinational x of segment rd_idx.
- rd_y  out  YW  combinational y of segment rd_idx.
- rd_valid  out  1  rd_idx < length.

Behaviour:
- Reset or init: the highest-priority event, acting in any state including mid-scan.
  - Segment i = (X_INIT - i*STEP, Y_INIT) for i < INIT_LEN; all other segments = (0,0).
  - length = INIT_LEN; heading = right; hit flags = 0; state = IDLE.
  - busy = 0 and done = 0.
- FSM states: IDLE, CHECK, DONE.
  - busy = (state != IDLE); done = (state == DONE).
- IDLE:
  - If step=1 and hit_wall=0 and hit_self=0, the step is accepted on that edge.
  - Otherwise stay in IDLE.
  - A step while busy, or while either hit flag is set, is ignored: no move and no done.
- Heading update at acceptance:
  - If dir is the exact opposite of the current heading, the heading is unchanged.
  - Otherwise heading = dir.
- Wall check at acceptance (next head computed in XW+1 / YW+1 bits):
  - Left with head_x < STEP is blocked.
  - Right with head_x + STEP > XMAX is blocked.
  - Up with head_y < STEP is blocked.
  - Down with head_y + STEP > YMAX is blocked.
  - If blocked: set hit_wall; no shift; no length change; go to DONE.
- Move at acceptance, when not blocked:
  - Segments shift by one: seg[i] <= seg[i-1]; seg[0] <= next head.
  - If grow=1 and length < MAX_LEN, length increments and the old tail is retained.
  - If grow=1 and length = MAX_LEN, the grow request is dropped and the step is still taken.
  - Then go to CHECK with scan index 1, or directly to DONE if the new length = 1.
- CHECK:
  - Each cycle compares seg[idx] with seg[0]; a match sets hit_self.
  - idx increments; leave for DONE after idx = length-1 has been compared.
  - The scan always runs to completion, even after a hit.
- DONE: one cycle, then IDLE.
- Latency: done is high in the cycle after L edges from acceptance, where L = new length; blocked moves take 1 edge.
- Read port:
  - Purely combinational.
  - rd_idx >= length returns (0,0) with rd_valid = 0.
  - Storage changes only at the acceptance edge, so reads during CHECK/DONE are stable.

Decomposition:
- Shared package snake_pkg holds:
  - direction encodings: DIR_RIGHT=2'b00, DIR_DOWN=2'b01, DIR_UP=2'b10, DIR_LEFT=2'b11;
  - the state encodings;
  - an opposite-direction function (dir ^ 2'b11).
- One sub-module, snake_seg_store:
  - a MAX_LEN-deep coordinate-pair register file;
  - load-initial, shift-in-head, and combinational indexed read.
- The FSM, wall logic, heading register and length counter stay in the parent.

Test Plan (default parameters):
- Reset -> length=2, seg0=(40,60), seg1=(30,60), rd_idx=2 gives rd_valid=0, busy=0, both flags 0.
- Step dir=00 -> busy for 2 cycles, then done pulse; seg0=(50,60), seg1=(40,60), length=2. A step issued while busy is ignored.
- After the right move, step dir=11 (reversal) -> heading stays right; head=(60,60).
- From reset, 3 steps dir=01 with grow=1 -> length=5; segments (40,90),(40,80),(40,70),(40,60),(30,60).
- From reset, 7 steps dir=10 -> the first 6 move the head to (40,0); the 7th sets hit_wall and pulses done with the head still at (40,0); an 8th step produces no done. init clears hit_wall and restores (40,60).
- From reset, 4 right steps with grow=1, then down, left, up -> head (70,60) matches seg[4], so hit_self=1 at done. An init asserted mid-CHECK returns the block to IDLE with the initial snake.
